btap_predictor: RTL and testbench
=================================

# btap_predictor

Branch target address predictor feeding the fetch stage of the superscalar MIPS pipeline. It holds a 32-entry direct-mapped table of branch targets with 2-bit saturating direction counters. Fetch reads it combinationally each cycle to get a taken/not-taken prediction and target. EX writes it back as branches resolve, closing the loop for the branch-resolution outputs EX produces (index, target, mispredict).

## Interface
Parameters:
- ENTRIES, 32: table depth, fixed; index is PC[6:2].
- CNTW, 16: width of the mispredict performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- PCF  in  32  fetch PC to predict.
- PredTakenF  out  1  prediction for PCF: 1 means taken.
- PredTargetF  out  32  predicted target. Valid when PredTakenF=1, else equals PCF+4.
- UpdEn  in  1  a branch resolved in EX this cycle.
- UpdPC  in  32  PC of the resolved branch instruction.
- UpdTaken  in  1  resolved direction (BranchTaken in EX).
- UpdTarget  in  32  resolved branch target, (ExtImm<<2)+PC+4.
- UpdMispred  in  1  EX prediction disagreed with outcome (PCSrc).
- MispredCount  out  CNTW  saturating count of mispredicted resolved branches.

## Operation
- Entry fields: valid (1), tag = PC[31:7] (25), target (32), ctr (2).
- Read, combinational from current state:
  - idx = PCF[6:2].
  - hit = valid[idx] & (tag[idx] == PCF[31:7]).
  - PredTakenF = hit & ctr[idx][1].
  - PredTargetF = PredTakenF ? target[idx] : PCF+4, with 32-bit wrap.
- Update, on rising edge when reset_n=1 and UpdEn=1:
  - u = UpdPC[6:2]; uhit = valid[u] & (tag[u] == UpdPC[31:7]).
  - uhit & UpdTaken: ctr = min(ctr+1, 3); target = UpdTarget.
  - uhit & !UpdTaken: ctr = max(ctr-1, 0); target unchanged.
  - !uhit & UpdTaken: allocate. valid=1, tag=UpdPC[31:7], target=UpdTarget, ctr=2'b10 (weakly taken). This replaces any previous occupant.
  - !uhit & !UpdTaken: no table change. There is no allocation on not-taken.
- When UpdEn=0, the table is unchanged. UpdTaken, UpdTarget and UpdMispred are ignored.
- MispredCount increments when UpdEn & UpdMispred, and holds at 2^CNTW-1 (saturates, no wrap).
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Only bit 1 drives the prediction.

## Timing
- Read latency 0. PredTakenF and PredTargetF are a pure function of PCF and the registered table.
- Update latency 1. The write is visible to reads in the cycle after the edge.
- Same-cycle read of the entry being updated returns the pre-update value. There is no bypass.
- Aliasing: two PCs with equal [6:2] and different [31:7] evict each other. Each allocation overwrites the entry completely.
- Reset, when reset_n=0 at a rising edge:
  - all valid=0, all ctr=01, all target=0, all tag=0, MispredCount=0.
  - the same edge ignores UpdEn.
- After reset, PredTakenF=0 and PredTargetF=PCF+4 for every PCF.
- Reset asserted mid-operation wins over a simultaneous update. The table comes up empty on the next cycle.
- PCF=0xFFFFFFFC: PCF+4 wraps to 0x00000000.
- One update port only. The issue logic guarantees that at most one branch resolves per cycle.

## Test plan
- Reset, then sweep PCF over 0x0000_0000..0x0000_007C: PredTakenF=0 and PredTargetF=PCF+4 at every step. MispredCount=0.
- UpdEn=1, UpdPC=0x0040_0010, UpdTaken=1, UpdTarget=0x0040_0100, UpdMispred=1:
  - next cycle PCF=0x0040_0010 gives PredTakenF=1, PredTargetF=0x0040_0100, MispredCount=1.
  - same cycle as the update, the old prediction (0) is still seen.
- On that entry, apply two not-taken updates: ctr goes 10→01→00.
  - PredTakenF=0 after the first update.
  - a following taken update gives ctr=01, so the prediction is still 0.
  - a second taken update gives ctr=10, so PredTakenF=1.
- Alias: allocate 0x0040_0010 (taken), then a taken update at 0x0080_0010 with target 0x0080_0200.
  - PCF=0x0040_0010 now misses, so PredTakenF=0.
  - PCF=0x0080_0010 predicts 0x0080_0200.
- Not-taken update at an invalid index, UpdPC=0x0000_0020: no allocation. The next read at 0x0000_0020 gives PredTakenF=0.
- Drive 70000 consecutive UpdEn=1 & UpdMispred=1 updates: MispredCount stops at 0xFFFF. A reset_n=0 edge mid-stream clears the count and the table on the next cycle.

Source files
------------

// File: rtl/btap_predictor_if.sv
// Fetch/EX-facing bundle of the branch target predictor: the fetch-side read
// (PCF in, prediction out), the EX-side resolution update and the mispredict count.
interface btap_predictor_if #(parameter int CNTW = 16);
  logic [31:0]     PCF;
  logic            PredTakenF;
  logic [31:0]     PredTargetF;
  logic            UpdEn;
  logic [31:0]     UpdPC;
  logic            UpdTaken;
  logic [31:0]     UpdTarget;
  logic            UpdMispred;
  logic [CNTW-1:0] MispredCount;

  modport master (
    output PCF, UpdEn, UpdPC, UpdTaken, UpdTarget, UpdMispred,
    input  PredTakenF, PredTargetF, MispredCount
  );

  modport slave (
    input  PCF, UpdEn, UpdPC, UpdTaken, UpdTarget, UpdMispred,
    output PredTakenF, PredTargetF, MispredCount
  );
endinterface

// File: rtl/btap_predictor.sv
// Direct-mapped 32-entry branch target table with 2-bit direction counters.
// Read is combinational (0 cycles), update lands on the next edge; no backpressure.
module btap_predictor #(
  parameter int ENTRIES = 32,
  parameter int CNTW    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  btap_predictor_if.slave    bus
);
  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 32 - IW - 2;

  typedef logic [IW-1:0] idx_t;
  typedef logic [TW-1:0] tag_t;

  typedef struct packed {
    logic        valid;
    tag_t        tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } entry_t;

  localparam entry_t RST_ENT = {1'b0, {TW{1'b0}}, 32'd0, 2'b01};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  entry_t          tbl [ENTRIES];
  logic [CNTW-1:0] mis_cnt;

  // Fetch-side lookup
  idx_t   ridx;
  entry_t rent;
  logic   rhit;
  logic   rtaken;

  assign ridx   = bus.PCF[IW+1:2];
  assign rent   = tbl[ridx];
  assign rhit   = rent.valid && (rent.tag == bus.PCF[31:IW+2]);
  assign rtaken = rhit && rent.ctr[1];

  assign bus.PredTakenF   = rtaken;
  assign bus.PredTargetF  = rtaken ? rent.target : (bus.PCF + 32'd4);
  assign bus.MispredCount = mis_cnt;

  // EX-side resolution: a miss only allocates on taken, so cold not-taken
  // branches never displace a useful entry.
  idx_t   uidx;
  entry_t uent;
  logic   uhit;
  logic   wr_en;
  entry_t wr_ent;

  assign uidx = bus.UpdPC[IW+1:2];
  assign uent = tbl[uidx];
  assign uhit = uent.valid && (uent.tag == bus.UpdPC[31:IW+2]);

  always_comb begin
    wr_en  = 1'b0;
    wr_ent = uent;
    if (bus.UpdEn) begin
      if (uhit) begin
        wr_en = 1'b1;
        if (bus.UpdTaken) begin
          wr_ent.ctr    = (uent.ctr == 2'b11) ? 2'b11 : uent.ctr + 2'd1;
          wr_ent.target = bus.UpdTarget;
        end else begin
          wr_ent.ctr = (uent.ctr == 2'b00) ? 2'b00 : uent.ctr - 2'd1;
        end
      end else if (bus.UpdTaken) begin
        wr_en         = 1'b1;
        wr_ent.valid  = 1'b1;
        wr_ent.tag    = bus.UpdPC[31:IW+2];
        wr_ent.target = bus.UpdTarget;
        wr_ent.ctr    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= RST_ENT;
      end
      mis_cnt <= '0;
    end else begin
      if (wr_en) begin
        tbl[uidx] <= wr_ent;
      end
      if (bus.UpdEn && bus.UpdMispred && (mis_cnt != CNT_MAX)) begin
        mis_cnt <= mis_cnt + CNT_ONE;
      end
    end
  end
endmodule

// File: tb/tb_btap_predictor.sv
// Bench for btap_predictor: per-cycle vectors are applied after the rising edge and
// their expected read-side results are queued, then popped and compared at the falling edge.
module tb_btap_predictor;
  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  btap_predictor_if #(.CNTW(16)) bus ();

  btap_predictor #(.ENTRIES(32), .CNTW(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int          id;
    logic        rst_n;
    logic        en;
    logic [31:0] upc;
    logic        tk;
    logic [31:0] utgt;
    logic        mis;
    logic [31:0] pcf;
    logic        chk;
    logic        etk;
    logic [31:0] etgt;
    logic [15:0] ecnt;
  } vec_t;

  vec_t sb [$];
  vec_t tbl [$];
  vec_t e;
  int   checks = 0;
  int   errors = 0;
  int   nrow = 0;

  function automatic vec_t mk(input logic rst_n, input logic en, input logic [31:0] upc,
                              input logic tk, input logic [31:0] utgt, input logic mis,
                              input logic [31:0] pcf, input logic chk, input logic etk,
                              input logic [31:0] etgt, input logic [15:0] ecnt);
    vec_t v;
    v.id = 0; v.rst_n = rst_n; v.en = en; v.upc = upc; v.tk = tk; v.utgt = utgt;
    v.mis = mis; v.pcf = pcf; v.chk = chk; v.etk = etk; v.etgt = etgt; v.ecnt = ecnt;
    return v;
  endfunction

  // Read-only cycle with an expected prediction
  function automatic vec_t rd(input logic [31:0] pcf, input logic etk,
                              input logic [31:0] etgt, input logic [15:0] ecnt);
    return mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, pcf, 1'b1, etk, etgt, ecnt);
  endfunction

  // Update cycle; the expectation is the pre-update read in the same cycle
  function automatic vec_t up(input logic [31:0] upc, input logic tk, input logic [31:0] utgt,
                              input logic mis, input logic [31:0] pcf, input logic etk,
                              input logic [31:0] etgt, input logic [15:0] ecnt);
    return mk(1'b1, 1'b1, upc, tk, utgt, mis, pcf, 1'b1, etk, etgt, ecnt);
  endfunction

  task automatic apply(input vec_t v);
    vec_t w;
    w = v;
    w.id = nrow;
    nrow++;
    @(posedge clk);
    #1;
    reset_n        = w.rst_n;
    bus.UpdEn      = w.en;
    bus.UpdPC      = w.upc;
    bus.UpdTaken   = w.tk;
    bus.UpdTarget  = w.utgt;
    bus.UpdMispred = w.mis;
    bus.PCF        = w.pcf;
    if (w.chk) sb.push_back(w);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.PredTakenF !== e.etk) begin
        errors++;
        $display("FAIL row %0d taken pcf=%h: got %b expected %b", e.id, e.pcf, bus.PredTakenF, e.etk);
      end
      checks++;
      if (bus.PredTargetF !== e.etgt) begin
        errors++;
        $display("FAIL row %0d target pcf=%h: got %h expected %h", e.id, e.pcf, bus.PredTargetF, e.etgt);
      end
      checks++;
      if (bus.MispredCount !== e.ecnt) begin
        errors++;
        $display("FAIL row %0d mispred_count: got %0d expected %0d", e.id, bus.MispredCount, e.ecnt);
      end
    end
  end

  localparam logic [31:0] A  = 32'h0040_0010;
  localparam logic [31:0] TA = 32'h0040_0100;
  localparam logic [31:0] TA2 = 32'h0040_0200;
  localparam logic [31:0] B  = 32'h0080_0010;
  localparam logic [31:0] TB = 32'h0080_0200;
  localparam logic [31:0] C  = 32'h0000_0020;

  initial begin
    bus.PCF = 32'h0; bus.UpdEn = 1'b0; bus.UpdPC = 32'h0; bus.UpdTaken = 1'b0;
    bus.UpdTarget = 32'h0; bus.UpdMispred = 1'b0;

    // Reset, then sweep every index and the wrap-around PC
    tbl.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 16'd0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 16'd0));
    for (int i = 0; i < 32; i++) begin
      tbl.push_back(rd(32'(i * 4), 1'b0, 32'(i * 4 + 4), 16'd0));
    end
    tbl.push_back(rd(32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 16'd0));

    // Allocation, counter walk both directions including both saturation points
    tbl.push_back(up(A, 1'b1, TA,  1'b1, A, 1'b0, A + 32'd4, 16'd0));
    tbl.push_back(rd(A, 1'b1, TA, 16'd1));
    tbl.push_back(up(A, 1'b0, 32'h0, 1'b1, A, 1'b1, TA, 16'd1));
    tbl.push_back(rd(A, 1'b0, A + 32'd4, 16'd2));
    tbl.push_back(up(A, 1'b0, 32'h0, 1'b0, A, 1'b0, A + 32'd4, 16'd2));
    tbl.push_back(up(A, 1'b0, 32'h0, 1'b0, A, 1'b0, A + 32'd4, 16'd2));
    tbl.push_back(up(A, 1'b1, TA,  1'b1, A, 1'b0, A + 32'd4, 16'd2));
    tbl.push_back(rd(A, 1'b0, A + 32'd4, 16'd3));
    tbl.push_back(up(A, 1'b1, TA,  1'b0, A, 1'b0, A + 32'd4, 16'd3));
    tbl.push_back(rd(A, 1'b1, TA, 16'd3));
    tbl.push_back(up(A, 1'b1, TA2, 1'b0, A, 1'b1, TA, 16'd3));
    tbl.push_back(up(A, 1'b1, TA2, 1'b0, A, 1'b1, TA2, 16'd3));
    tbl.push_back(up(A, 1'b0, 32'h0, 1'b0, A, 1'b1, TA2, 16'd3));
    tbl.push_back(rd(A, 1'b1, TA2, 16'd3));
    // Alias eviction; a not-taken miss must leave the new occupant alone
    tbl.push_back(up(B, 1'b1, TB, 1'b1, B, 1'b0, B + 32'd4, 16'd3));
    tbl.push_back(rd(A, 1'b0, A + 32'd4, 16'd4));
    tbl.push_back(rd(B, 1'b1, TB, 16'd4));
    tbl.push_back(up(A, 1'b0, 32'h0, 1'b0, B, 1'b1, TB, 16'd4));
    tbl.push_back(rd(B, 1'b1, TB, 16'd4));
    // No allocation on not-taken; then a taken allocation at the same PC
    tbl.push_back(up(C, 1'b0, 32'h0, 1'b0, C, 1'b0, 32'h24, 16'd4));
    tbl.push_back(rd(C, 1'b0, 32'h24, 16'd4));
    tbl.push_back(up(C, 1'b1, 32'h80, 1'b0, 32'h24, 1'b0, 32'h28, 16'd4));
    tbl.push_back(rd(C, 1'b1, 32'h80, 16'd4));
    // UpdEn low: other update fields are ignored
    tbl.push_back(mk(1'b1, 1'b0, C, 1'b0, 32'h0, 1'b1, C, 1'b1, 1'b1, 32'h80, 16'd4));
    tbl.push_back(rd(C, 1'b1, 32'h80, 16'd4));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Reset wins over a simultaneous taken update; table comes up empty
    apply(mk(1'b0, 1'b1, 32'h40, 1'b1, 32'h600, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 16'd0));
    apply(rd(C, 1'b0, 32'h24, 16'd0));
    apply(rd(B, 1'b0, B + 32'd4, 16'd0));
    apply(rd(32'h40, 1'b0, 32'h44, 16'd0));
    apply(rd(A, 1'b0, A + 32'd4, 16'd0));

    // Mispredict counter saturation over a long stream
    for (int k = 0; k < 70000; k++) begin
      logic c;
      c = (k == 0) || (k == 1) || (k == 65534) || (k == 65535) || (k == 65536) || (k == 69999);
      apply(mk(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h0, c, 1'b0, 32'h4,
               (k > 65535) ? 16'hFFFF : 16'(k)));
    end
    // Reset mid-stream clears the count and the table
    apply(mk(1'b0, 1'b1, 32'h0, 1'b1, 32'h500, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 16'd0));
    apply(mk(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 16'd0));
    apply(rd(32'h0, 1'b0, 32'h4, 16'd1));
    apply(rd(C, 1'b0, 32'h24, 16'd1));

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
